// File: rtl/next_pc_if.sv
// Bundle between the decoder/datapath and the next-PC stage.
// It carries the branch/jump strobes, the operand results and the PC/link outputs.
interface next_pc_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                stall_i;
  logic                rformat_i;
  logic                beq_i;
  logic                blez_i;
  logic                jal_i;
  logic                jmor_i;
  logic                balrn_i;
  logic [15:0]         imm16_i;
  logic [25:0]         target26_i;
  logic [4:0]          rd_i;
  logic                alu_zero_i;
  logic [PC_WIDTH-1:0] alu_result_i;
  logic                status_we_i;
  logic [PC_WIDTH-1:0] rs_data_i;
  logic [PC_WIDTH-1:0] mem_rdata_i;

  logic [PC_WIDTH-1:0] pc_o;
  logic [PC_WIDTH-1:0] pc_plus4_o;
  logic                link_we_o;
  logic [4:0]          link_addr_o;
  logic [PC_WIDTH-1:0] link_data_o;
  logic                status_n_o;
  logic                status_z_o;
  logic                misalign_o;
  logic [31:0]         retired_o;

  modport master (
    output stall_i, rformat_i, beq_i, blez_i, jal_i, jmor_i, balrn_i,
           imm16_i, target26_i, rd_i, alu_zero_i, alu_result_i,
           status_we_i, rs_data_i, mem_rdata_i,
    input  pc_o, pc_plus4_o, link_we_o, link_addr_o, link_data_o,
           status_n_o, status_z_o, misalign_o, retired_o
  );

  modport slave (
    input  stall_i, rformat_i, beq_i, blez_i, jal_i, jmor_i, balrn_i,
           imm16_i, target26_i, rd_i, alu_zero_i, alu_result_i,
           status_we_i, rs_data_i, mem_rdata_i,
    output pc_o, pc_plus4_o, link_we_o, link_addr_o, link_data_o,
           status_n_o, status_z_o, misalign_o, retired_o
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC stage: owns the PC, the N/Z status flags, the link write request
// and the retired-instruction counter; selects the next PC by fixed priority.
module next_pc_unit #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [4:0]          LINK_REG = 5'd31
) (
  input logic       clk,
  input logic       rst_n,
  next_pc_if.slave  bus
);

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_JMOR,
    SRC_BALRN,
    SRC_JAL,
    SRC_BRANCH
  } pc_src_e;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] branch_off;
  logic                status_n_q;
  logic                status_z_q;
  logic                misalign_q;
  logic [31:0]         retired_q;

  logic    jmor;
  logic    balrn_taken;
  logic    beq_taken;
  logic    blez_taken;
  pc_src_e pc_src;

  logic    link_we;
  logic [4:0] link_addr;

  logic    unused_alu_bits;

  assign pc_plus4    = pc_q + PC_WIDTH'(4);
  assign branch_off  = {{(PC_WIDTH-18){bus.imm16_i[15]}}, bus.imm16_i, 2'b00};

  // funct strobes are only meaningful when the opcode is R-format
  assign jmor        = bus.jmor_i & bus.rformat_i;
  assign balrn_taken = bus.balrn_i & bus.rformat_i & status_n_q;
  assign beq_taken   = bus.beq_i & bus.alu_zero_i;
  assign blez_taken  = bus.blez_i &
                       (bus.rs_data_i[PC_WIDTH-1] | (bus.rs_data_i == '0));

  always_comb begin
    pc_src = SRC_SEQ;
    if (jmor)                          pc_src = SRC_JMOR;
    else if (balrn_taken)              pc_src = SRC_BALRN;
    else if (bus.jal_i)                pc_src = SRC_JAL;
    else if (beq_taken || blez_taken)  pc_src = SRC_BRANCH;
  end

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      SRC_JMOR:   next_pc = {bus.mem_rdata_i[PC_WIDTH-1:2], 2'b00};
      SRC_BALRN:  next_pc = {bus.rs_data_i[PC_WIDTH-1:2], 2'b00};
      SRC_JAL:    next_pc = {pc_plus4[PC_WIDTH-1:28], bus.target26_i, 2'b00};
      SRC_BRANCH: next_pc = pc_plus4 + branch_off;
      default:    next_pc = pc_plus4;
    endcase
  end

  // Link follows the winning source, so a jal beaten by jmor does not link.
  always_comb begin
    link_we   = 1'b0;
    link_addr = '0;
    if (rst_n && !bus.stall_i) begin
      if (pc_src == SRC_JAL) begin
        link_we   = 1'b1;
        link_addr = LINK_REG;
      end else if (pc_src == SRC_BALRN) begin
        link_we   = 1'b1;
        link_addr = bus.rd_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      status_n_q <= 1'b0;
      status_z_q <= 1'b0;
      misalign_q <= 1'b0;
      retired_q  <= '0;
    end else if (!bus.stall_i) begin
      pc_q      <= next_pc;
      retired_q <= retired_q + 32'd1;
      if (bus.status_we_i) begin
        status_n_q <= bus.alu_result_i[PC_WIDTH-1];
        status_z_q <= bus.alu_zero_i;
      end
      if (jmor && (bus.mem_rdata_i[1:0] != 2'b00))
        misalign_q <= 1'b1;
    end
  end

  assign unused_alu_bits = ^bus.alu_result_i[PC_WIDTH-2:0];

  assign bus.pc_o        = pc_q;
  assign bus.pc_plus4_o  = pc_plus4;
  assign bus.link_we_o   = link_we;
  assign bus.link_addr_o = link_addr;
  assign bus.link_data_o = pc_plus4;
  assign bus.status_n_o  = status_n_q;
  assign bus.status_z_o  = status_z_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.retired_o   = retired_q;

endmodule
